bcd_display_counter: RTL and testbench

- Parametrised successor to the team's single-digit seconds counter.
- Counts ticks from a prescaler into a DIGITS-wide BCD counter. Count direction is selectable, and the counter supports synchronous clear and parallel load.
- Drives a time-multiplexed common 7-segment bus, with a one-hot digit select.
- Sits between the board clock and the display/GPIO pins in the top-level wrapper.

---
 rtl/bcd_display_pkg.sv | 23 ++
 rtl/bcd_digit.sv | 52 +++++
 rtl/bcd_display_counter.sv | 141 ++++++++++++++
 tb/tb_bcd_display_counter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_display_pkg.sv
// Shared types, segment glyphs and the BCD-to-7-segment decoder.
package bcd_display_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Segment order: bit0 = a ... bit6 = g, active high.
    localparam logic [6:0] SEG_GLYPH [10] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    function automatic logic [6:0] seg_decode(input bcd_digit_t d);
        logic [6:0] seg;
        seg = SEG_BLANK;
        if (d <= 4'd9) begin
            seg = SEG_GLYPH[d];
        end
        return seg;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the ripple counter: steps when the chain reaches it,
// reports carry (up) or borrow (down) to the next digit.
module bcd_digit
    import bcd_display_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena_i,
    input  logic       clear_i,
    input  logic       load_i,
    input  bcd_digit_t load_val_i,
    input  logic       step_en_i,
    input  logic       up_dn_i,
    input  logic       cin_i,
    output logic       cout_o,
    output bcd_digit_t digit_o
);

    bcd_digit_t digit_q;
    bcd_digit_t digit_d;
    logic       at_limit;

    assign at_limit = up_dn_i ? (digit_q >= 4'd9) : (digit_q == 4'd0);
    assign cout_o   = cin_i && at_limit;
    assign digit_o  = digit_q;

    always_comb begin
        digit_d = digit_q;
        if (ena_i) begin
            if (clear_i) begin
                digit_d = '0;
            end else if (load_i) begin
                digit_d = (load_val_i > 4'd9) ? 4'd9 : load_val_i;
            end else if (step_en_i && cin_i) begin
                if (up_dn_i) begin
                    digit_d = at_limit ? 4'd0 : digit_q + 4'd1;
                end else begin
                    digit_d = at_limit ? 4'd9 : digit_q - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

endmodule

// File: rtl/bcd_display_counter.sv
// Prescaled up/down BCD counter driving a multiplexed 7-segment display.
// Define BCD_DISPLAY_BLANK_LEADING_EN to blank leading zero digits.
module bcd_display_counter
    import bcd_display_pkg::*;
#(
    parameter int CLK_DIV  = 10_000_000,
    parameter int DIV_W    = 24,
    parameter int DIGITS   = 2,
    parameter int SCAN_DIV = 10_000,
    parameter int SCAN_W   = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  run,
    input  logic                  up_dn,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [6:0]            segments,
    output logic [DIGITS-1:0]     digit_sel,
    output logic                  tick,
    output logic                  wrap
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DIV_W-1:0]  PRESC_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(DIGITS - 1);

    logic [DIV_W-1:0]  presc_q, presc_d;
    logic [SCAN_W-1:0] scan_q, scan_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [6:0]        seg_q, seg_d;
    logic [DIGITS-1:0] sel_q, sel_d;
    logic              tick_q, wrap_q;

    logic              tick_cond;
    logic [DIGITS:0]   carry;
    bcd_digit_t        digit_val [DIGITS];
    logic [DIGITS-1:0] blank;
    bcd_digit_t        cur_digit;

    // clear and load take priority, so a coincident terminal count is dropped.
    assign tick_cond = ena && run && !clear && !load && (presc_q == PRESC_LAST);
    assign carry[0]  = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            bcd_digit u_digit (
                .clk        (clk),
                .rst_n      (rst_n),
                .ena_i      (ena),
                .clear_i    (clear),
                .load_i     (load),
                .load_val_i (load_val[4*gi +: 4]),
                .step_en_i  (tick_cond),
                .up_dn_i    (up_dn),
                .cin_i      (carry[gi]),
                .cout_o     (carry[gi+1]),
                .digit_o    (digit_val[gi])
            );
            assign bcd_out[4*gi +: 4] = digit_val[gi];
            assign sel_d[gi]          = (idx_q == IDX_W'(gi));
        end
    endgenerate

`ifdef BCD_DISPLAY_BLANK_LEADING_EN
    // zero_above[i]: digit i and every higher digit are zero.
    logic [DIGITS:1] zero_above;
    assign zero_above[DIGITS] = 1'b1;
    assign blank[0]           = 1'b0;
    generate
        for (gi = 1; gi < DIGITS; gi++) begin : g_blank
            assign zero_above[gi] = zero_above[gi+1] && (digit_val[gi] == 4'd0);
            assign blank[gi]      = zero_above[gi];
        end
    endgenerate
`else
    assign blank = '0;
`endif

    always_comb begin
        presc_d = presc_q;
        if (ena) begin
            if (clear || load) begin
                presc_d = '0;
            end else if (run) begin
                presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
            end
        end
    end

    always_comb begin
        scan_d = scan_q;
        idx_d  = idx_q;
        if (ena) begin
            if (scan_q == SCAN_LAST) begin
                scan_d = '0;
                idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end else begin
                scan_d = scan_q + 1'b1;
            end
        end
    end

    always_comb begin
        cur_digit = digit_val[idx_q];
        seg_d     = blank[idx_q] ? SEG_BLANK : seg_decode(cur_digit);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            scan_q  <= '0;
            idx_q   <= '0;
            seg_q   <= SEG_GLYPH[0];
            sel_q   <= DIGITS'(1);
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            scan_q  <= scan_d;
            idx_q   <= idx_d;
            tick_q  <= tick_cond;
            wrap_q  <= tick_cond && carry[DIGITS];
            if (ena) begin
                seg_q <= seg_d;
                sel_q <= sel_d;
            end
        end
    end

    assign segments  = seg_q;
    assign digit_sel = sel_q;
    assign tick      = tick_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_bcd_display_counter.sv
// Scoreboard bench: an arithmetic model predicts every tick; a monitor checks them.
module tb_bcd_display_counter;

    localparam int CLK_DIV  = 4;
    localparam int DIV_W    = 3;
    localparam int DIGITS   = 2;
    localparam int SCAN_DIV = 2;
    localparam int SCAN_W   = 2;
    localparam int MOD      = 10 ** DIGITS;

`ifdef BCD_DISPLAY_BLANK_LEADING_EN
    localparam logic [6:0] LEAD_ZERO_SEG = 7'h00;
`else
    localparam logic [6:0] LEAD_ZERO_SEG = 7'h3F;
`endif

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                ena = 1'b0;
    logic                run = 1'b0;
    logic                up_dn = 1'b1;
    logic                clear = 1'b0;
    logic                load = 1'b0;
    logic [4*DIGITS-1:0] load_val = '0;
    logic [4*DIGITS-1:0] bcd_out;
    logic [6:0]          segments;
    logic [DIGITS-1:0]   digit_sel;
    logic                tick;
    logic                wrap;

    always #5 clk = ~clk;

    bcd_display_counter #(
        .CLK_DIV (CLK_DIV),
        .DIV_W   (DIV_W),
        .DIGITS  (DIGITS),
        .SCAN_DIV(SCAN_DIV),
        .SCAN_W  (SCAN_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .run      (run),
        .up_dn    (up_dn),
        .clear    (clear),
        .load     (load),
        .load_val (load_val),
        .bcd_out  (bcd_out),
        .segments (segments),
        .digit_sel(digit_sel),
        .tick     (tick),
        .wrap     (wrap)
    );

    typedef struct {
        int cyc;
        int cnt;
        bit wrp;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   m_cnt = 0;
    int   m_pre = 0;
    bit   mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
        logic [4*DIGITS-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int clamp_val(input logic [4*DIGITS-1:0] lv);
        int v;
        int scale;
        int nib;
        v = 0;
        scale = 1;
        for (int i = 0; i < DIGITS; i++) begin
            nib = int'(lv[4*i +: 4]);
            v += ((nib > 9) ? 9 : nib) * scale;
            scale *= 10;
        end
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Count as an integer modulo 10^DIGITS; a tick every CLK_DIV enabled run cycles.
    task automatic model_step();
        bit w;
        if (!ena) return;
        if (clear) begin
            m_cnt = 0;
            m_pre = 0;
        end else if (load) begin
            m_cnt = clamp_val(load_val);
            m_pre = 0;
        end else if (run) begin
            if (m_pre == CLK_DIV - 1) begin
                m_pre = 0;
                w = up_dn ? (m_cnt == MOD - 1) : (m_cnt == 0);
                m_cnt = up_dn ? (m_cnt + 1) % MOD : (m_cnt + MOD - 1) % MOD;
                sb_q.push_back('{cyc + 1, m_cnt, w});
            end else begin
                m_pre++;
            end
        end
    endtask

    task automatic drive(input bit e, input bit r, input bit u, input bit c, input bit l,
                         input logic [4*DIGITS-1:0] lv);
        ena = e; run = r; up_dn = u; clear = c; load = l; load_val = lv;
        model_step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en && rst_n) begin
            while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
                n_checks++;
                n_errors++;
                $display("FAIL tick_missing: no tick at cycle %0d, expected count 0x%0h",
                         sb_q[0].cyc, to_bcd(sb_q[0].cnt));
                void'(sb_q.pop_front());
            end
            if (tick) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_tick: tick at cycle %0d, bcd_out 0x%0h", cyc, bcd_out);
                end else begin
                    e = sb_q.pop_front();
                    chk("tick_cycle", 32'(cyc), 32'(e.cyc));
                    chk("tick_count", 32'(bcd_out), 32'(to_bcd(e.cnt)));
                    chk("tick_wrap", 32'(wrap), 32'(e.wrp));
                end
            end else if (wrap) begin
                chk("wrap_without_tick", 32'(wrap), 32'd0);
            end
        end
    end

    logic [DIGITS-1:0]   sel_hist [8];
    logic [4*DIGITS-1:0] frz_bcd;
    logic [DIGITS-1:0]   frz_sel;
    logic [4*DIGITS-1:0] rnd_lv;

    initial begin
        #12;
        chk("reset_bcd", 32'(bcd_out), 32'h00);
        chk("reset_tick", 32'(tick), 32'd0);
        chk("reset_wrap", 32'(wrap), 32'd0);
        chk("reset_sel", 32'(digit_sel), 32'h1);
        chk("reset_seg", 32'(segments), 32'h3F);
        #6 rst_n = 1'b1;
        mon_en = 1'b1;

        // Count up through the 0x09 -> 0x10 carry.
        repeat (44) drive(1, 1, 1, 0, 0, '0);

        drive(1, 1, 1, 0, 1, 8'h98);
        chk("load_98", 32'(bcd_out), 32'h98);
        repeat (8) drive(1, 1, 1, 0, 0, '0);

        repeat (8) drive(1, 1, 0, 0, 0, '0);
        drive(1, 1, 0, 0, 1, 8'h10);
        chk("load_10", 32'(bcd_out), 32'h10);
        repeat (4) drive(1, 1, 0, 0, 0, '0);

        // clear + load on the terminal prescaler cycle.
        for (int i = 0; i < CLK_DIV && m_pre != CLK_DIV - 1; i++) drive(1, 1, 1, 0, 0, '0);
        drive(1, 1, 1, 1, 1, 8'h55);
        chk("clr_ld_bcd", 32'(bcd_out), 32'h00);
        chk("clr_ld_tick", 32'(tick), 32'd0);
        repeat (4) drive(1, 1, 1, 0, 0, '0);

        drive(1, 0, 1, 0, 1, 8'hFA);
        chk("load_clamp", 32'(bcd_out), 32'h99);

        drive(1, 0, 1, 0, 1, 8'h05);
        repeat (3) drive(1, 0, 1, 0, 0, '0);
        for (int i = 0; i < 4; i++) begin
            if (digit_sel == 2'b10) chk("lead_zero_seg", 32'(segments), 32'(LEAD_ZERO_SEG));
            else                    chk("digit0_seg_5", 32'(segments), 32'h6D);
            drive(1, 0, 1, 0, 0, '0);
        end

        drive(1, 0, 1, 0, 1, 8'h37);
        repeat (3) drive(1, 0, 1, 0, 0, '0);
        for (int i = 0; i < 8; i++) begin
            sel_hist[i] = digit_sel;
            chk("scan_onehot", 32'($onehot(digit_sel)), 32'd1);
            chk("scan_seg", 32'(segments), (digit_sel == 2'b01) ? 32'h07 : 32'h4F);
            drive(1, 0, 1, 0, 0, '0);
        end
        for (int i = 0; i < 6; i++) begin
            chk("scan_alternate", 32'(sel_hist[i] != sel_hist[i+2]), 32'd1);
        end

        // Freeze with ena low; the load attempted mid-freeze must be ignored.
        repeat (6) drive(1, 1, 1, 0, 0, '0);
        frz_bcd = bcd_out;
        frz_sel = digit_sel;
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, 1, (i == 3), (i == 5), 8'h42);
            chk("freeze_bcd", 32'(bcd_out), 32'(frz_bcd));
            chk("freeze_sel", 32'(digit_sel), 32'(frz_sel));
            chk("freeze_tick", 32'(tick), 32'd0);
        end
        repeat (8) drive(1, 1, 1, 0, 0, '0);

        for (int i = 0; i < 600; i++) begin
            rnd_lv = ($urandom_range(0, 2) == 0) ? (($urandom_range(0, 1) == 1) ? 8'h99 : 8'h00)
                                                 : 8'($urandom);
            drive(($urandom_range(0, 9) != 0), ($urandom_range(0, 3) != 0), 1'($urandom),
                  ($urandom_range(0, 49) == 0), ($urandom_range(0, 29) == 0), rnd_lv);
        end

        // Asynchronous reset between clock edges.
        drive(1, 1, 1, 0, 1, 8'h46);
        repeat (6) drive(1, 1, 1, 0, 0, '0);
        #3;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("areset_bcd", 32'(bcd_out), 32'h00);
        chk("areset_tick", 32'(tick), 32'd0);
        chk("areset_wrap", 32'(wrap), 32'd0);
        chk("areset_sel", 32'(digit_sel), 32'h1);
        chk("areset_seg", 32'(segments), 32'h3F);
        sb_q.delete();
        m_cnt = 0;
        m_pre = 0;
        #2;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (12) drive(1, 1, 1, 0, 0, '0);

        repeat (3) drive(1, 0, 1, 0, 0, '0);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
